// File: rtl/load_store_unit.sv
// Load/store unit: MEM-stage memory access over a req/ack data bus with
// IDLE/BUSY/DONE sequencing, byte/half/word lanes, ack timeout and faults.
// Ports: clk, rst (async, active low); MemReadM/MemWriteM/funct3M/
//   ALUResultM/rd2M in; ReadDataM/StallM/MemFaultM out;
//   bus_req/bus_we/bus_addr/bus_wdata/bus_be out; bus_ack/bus_rdata in.
// Param TIMEOUT_CYCLES: BUSY cycles to wait for bus_ack before faulting.
// Macro LSU_MISALIGN_TRAP_EN: fault misaligned half/word accesses
//   instead of silently ignoring the low address bits.
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] rd2M,
  output logic [31:0] ReadDataM,
  output logic        StallM,
  output logic        MemFaultM,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [1:0]    size_q;
  logic          uns_q;
  logic [1:0]    ofs_q;

  logic          req;
  logic [1:0]    sz;
  logic          bad;
  logic          mis;
  logic [3:0]    be_n;
  logic [31:0]   wd_n;
  logic [7:0]    lane_b;
  logic [15:0]   lane_h;
  logic [31:0]   ld_val;

  assign req = MemReadM | MemWriteM;
  assign sz  = funct3M[1:0];
  assign bad = (sz == 2'b11) ||
               (sz == 2'b10 && funct3M[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign mis = (sz == 2'b01 && ALUResultM[0]) ||
               (sz == 2'b10 && ALUResultM[1:0] != 2'b00);
`else
  assign mis = 1'b0;
`endif

  // Stall is combinational so the pipeline freezes in the request cycle.
  assign StallM = rst &
                  ((state == IDLE && req) || state == BUSY);

  always_comb begin
    be_n = 4'b1111;
    wd_n = rd2M;
    unique case (1'b1)
      sz == 2'b00: begin
        be_n = 4'b0001 << ALUResultM[1:0];
        wd_n = {4{rd2M[7:0]}};
      end
      sz == 2'b01: begin
        be_n = 4'b0011 << {ALUResultM[1], 1'b0};
        wd_n = {2{rd2M[15:0]}};
      end
      default: begin
        be_n = 4'b1111;
        wd_n = rd2M;
      end
    endcase
  end

  always_comb begin
    lane_b = 8'(bus_rdata >> {ofs_q, 3'b000});
    lane_h = ofs_q[1] ? bus_rdata[31:16]
                      : bus_rdata[15:0];
    ld_val = bus_rdata;
    unique case (1'b1)
      size_q == 2'b00:
        ld_val = {{24{~uns_q & lane_b[7]}}, lane_b};
      size_q == 2'b01:
        ld_val = {{16{~uns_q & lane_h[15]}}, lane_h};
      default:
        ld_val = bus_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      size_q    <= 2'b00;
      uns_q     <= 1'b0;
      ofs_q     <= 2'b00;
      bus_req   <= 1'b0;
      bus_we    <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      bus_be    <= '0;
      ReadDataM <= '0;
      MemFaultM <= 1'b0;
    end else begin
      MemFaultM <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req) begin
            if (bad || mis) begin
              state     <= DONE;
              MemFaultM <= 1'b1;
            end else begin
              state     <= BUSY;
              cnt       <= '0;
              bus_req   <= 1'b1;
              // Both strobes high resolves to a store.
              bus_we    <= MemWriteM;
              bus_addr  <= {ALUResultM[31:2], 2'b00};
              bus_wdata <= wd_n;
              bus_be    <= be_n;
              size_q    <= sz;
              uns_q     <= funct3M[2];
              ofs_q     <= ALUResultM[1:0];
            end
          end
        end
        BUSY: begin
          if (bus_ack) begin
            state   <= DONE;
            bus_req <= 1'b0;
            if (!bus_we) ReadDataM <= ld_val;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state     <= DONE;
            bus_req   <= 1'b0;
            MemFaultM <= 1'b1;
            if (!bus_we) ReadDataM <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Testbench for load_store_unit: directed and random accesses checked
// against an arithmetic reference of lanes, extension, latency and faults.
module tb_load_store_unit;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MemReadM = 1'b0;
  logic        MemWriteM = 1'b0;
  logic [2:0]  funct3M = '0;
  logic [31:0] ALUResultM = '0;
  logic [31:0] rd2M = '0;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MemFaultM;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] m_rdm = '0;
  logic        o_we;
  logic [3:0]  o_be;
  logic [31:0] o_addr;
  logic [31:0] o_wdata;
  int          o_busy;
  int          o_stall;

  load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .MemReadM   (MemReadM),
    .MemWriteM  (MemWriteM),
    .funct3M    (funct3M),
    .ALUResultM (ALUResultM),
    .rd2M       (rd2M),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MemFaultM  (MemFaultM),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_wdata  (bus_wdata),
    .bus_be     (bus_be),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // dly = BUSY cycles before ack (0 = first cycle); dly >= TO never acks.
  task automatic txn(input logic rd, input logic wr,
                     input logic [2:0] f3,
                     input logic [31:0] a, input logic [31:0] d,
                     input int dly, input logic [31:0] rdat);
    int sz;
    int ofs;
    int cyc;
    int busy_e;
    bit st;
    bit illegal;
    bit fault_e;
    logic [3:0]  be_e;
    logic [31:0] wd_e;
    logic [31:0] ld_e;
    sz  = int'(f3[1:0]);
    ofs = int'(a % 4);
    st  = wr;
    illegal = (sz == 3) || (sz == 2 && f3[2]);
`ifdef LSU_MISALIGN_TRAP_EN
    if ((sz == 1 && a % 2 != 0) || (sz == 2 && ofs != 0))
      illegal = 1'b1;
`endif
    if (sz == 0) begin
      be_e = 4'(1 << ofs);
      wd_e = d[7:0] * 32'h0101_0101;
      ld_e = (rdat >> (8 * ofs)) & 32'hFF;
      if (!f3[2] && ld_e >= 32'd128) ld_e = ld_e - 32'd256;
    end else if (sz == 1) begin
      be_e = 4'(3 << (2 * (ofs / 2)));
      wd_e = d[15:0] * 32'h0001_0001;
      ld_e = (rdat >> (16 * (ofs / 2))) & 32'hFFFF;
      if (!f3[2] && ld_e >= 32'd32768) ld_e = ld_e - 32'd65536;
    end else begin
      be_e = 4'hF;
      wd_e = d;
      ld_e = rdat;
    end
    busy_e  = illegal ? 0 : (dly < TO ? dly + 1 : TO);
    fault_e = illegal || dly >= TO;
    if (!illegal && !st) m_rdm = (dly < TO) ? ld_e : 32'd0;

    o_we = 1'b0; o_be = '0; o_addr = '0; o_wdata = '0;
    o_busy = 0; o_stall = 0; cyc = 0;

    @(negedge clk);
    MemReadM = rd; MemWriteM = wr; funct3M = f3;
    ALUResultM = a; rd2M = d;
    #1;
    while (StallM && cyc < 200) begin
      o_stall++;
      if (bus_req) begin
        o_busy++;
        if (o_busy == 1) begin
          o_we = bus_we; o_be = bus_be;
          o_addr = bus_addr; o_wdata = bus_wdata;
        end
        chk("bus_we", 32'(bus_we), 32'(st));
        chk("bus_addr", bus_addr, a & ~32'd3);
        chk("bus_be", 32'(bus_be), 32'(be_e));
        if (st) chk("bus_wdata", bus_wdata, wd_e);
        ALUResultM = $urandom;
        rd2M = $urandom;
        funct3M = 3'($urandom);
        bus_ack = (o_busy - 1 == dly);
        bus_rdata = bus_ack ? rdat : $urandom;
      end else begin
        bus_ack = 1'($urandom);
        bus_rdata = $urandom;
      end
      @(negedge clk); #1;
      cyc++;
    end
    chk("stall_end", 32'(StallM), 32'd0);
    chk("stall_cycles", o_stall, busy_e + 1);
    chk("busy_cycles", o_busy, busy_e);
    chk("fault", 32'(MemFaultM), 32'(fault_e));
    chk("req_done", 32'(bus_req), 32'd0);
    chk("read_data", ReadDataM, m_rdm);
    MemReadM = 1'b0; MemWriteM = 1'b0;
    bus_ack = 1'($urandom);
    @(negedge clk); #1;
    chk("fault_pulse", 32'(MemFaultM), 32'd0);
    chk("idle_stall", 32'(StallM), 32'd0);
    chk("idle_req", 32'(bus_req), 32'd0);
    bus_ack = 1'b0;
  endtask

  initial begin
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_stall", 32'(StallM), 32'd0);
    chk("rst_fault", 32'(MemFaultM), 32'd0);
    chk("rst_rdata", ReadDataM, 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    txn(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 0, 32'h80AA5511);
    chk("lb_be", 32'(o_be), 32'h8);
    chk("lb_data", ReadDataM, 32'hFFFFFF80);
    chk("lb_stall", o_stall, 2);

    txn(1'b0, 1'b1, 3'b001, 32'h202, 32'h1234ABCD, 0, 32'h0);
    chk("sh_we", 32'(o_we), 32'd1);
    chk("sh_be", 32'(o_be), 32'hC);
    chk("sh_wdata", o_wdata, 32'hABCDABCD);
    chk("sh_addr", o_addr, 32'h200);

    txn(1'b1, 1'b0, 3'b010, 32'h40, 32'h0, 5, 32'hDEADBEEF);
    chk("lw_busy", o_busy, 6);
    chk("lw_data", ReadDataM, 32'hDEADBEEF);

    txn(1'b1, 1'b0, 3'b010, 32'h44, 32'h0, 99, 32'h12345678);
    chk("to_busy", o_busy, TO);
    chk("to_data", ReadDataM, 32'd0);

    txn(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 0, 32'hCAFEF00D);
`ifdef LSU_MISALIGN_TRAP_EN
    chk("mis_busy", o_busy, 0);
`else
    chk("mis_addr", o_addr, 32'h100);
    chk("mis_be", 32'(o_be), 32'hF);
`endif

    txn(1'b1, 1'b0, 3'b011, 32'h10, 32'h0, 0, 32'h1);
    txn(1'b1, 1'b0, 3'b110, 32'h10, 32'h0, 0, 32'h1);
    txn(1'b1, 1'b0, 3'b101, 32'h2, 32'h0, 1, 32'h8001_7FFF);
    txn(1'b1, 1'b1, 3'b000, 32'h1, 32'h55, 0, 32'h0);
    txn(1'b1, 1'b0, 3'b010, 32'h48, 32'h0, TO - 1, 32'h0BAD_F00D);

    for (int i = 0; i < 60; i++) begin
      logic rd;
      logic wr;
      int   dly;
      rd  = 1'($urandom_range(0, 1));
      wr  = rd ? 1'($urandom_range(0, 1)) : 1'b1;
      dly = ($urandom_range(0, 9) == 0) ? 99
                                        : int'($urandom_range(0, 6));
      txn(rd, wr, 3'($urandom_range(0, 7)), $urandom, $urandom,
          dly, $urandom);
    end

    txn(1'b1, 1'b0, 3'b010, 32'h60, 32'h0, 0, 32'h7777_1111);
    @(negedge clk);
    MemReadM = 1'b1; funct3M = 3'b010; ALUResultM = 32'h300;
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("pre_rst_req", 32'(bus_req), 32'd1);
    rst = 1'b0;
    #1;
    chk("abort_req", 32'(bus_req), 32'd0);
    chk("abort_stall", 32'(StallM), 32'd0);
    chk("abort_fault", 32'(MemFaultM), 32'd0);
    chk("abort_rdata", ReadDataM, 32'd0);
    chk("abort_be", 32'(bus_be), 32'd0);
    chk("abort_we", 32'(bus_we), 32'd0);
    chk("abort_addr", bus_addr, 32'd0);
    chk("abort_wdata", bus_wdata, 32'd0);
    MemReadM = 1'b0;
    m_rdm = '0;
    @(negedge clk);
    rst = 1'b1;
    bus_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      chk("post_rst_req", 32'(bus_req), 32'd0);
      chk("post_rst_stall", 32'(StallM), 32'd0);
      chk("post_rst_fault", 32'(MemFaultM), 32'd0);
    end
    bus_ack = 1'b0;

    txn(1'b1, 1'b0, 3'b100, 32'h3, 32'h0, 2, 32'hF0E0_D0C0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
